alu_arbiter: RTL and testbench

- Shares a single `alu` instance between two requesters using valid/ready handshakes on both the request side and the response side.
- Arbitrates between the requesters (round-robin by default), registers the granted operands and drives them onto the shared ALU for one cycle.
- Captures the ALU result and flags, then holds the response until the owning requester accepts it.
- Sits in `pd0` between the requester logic and `alu_0`. It is the only driver of the ALU's `op1_i`, `op2_i` and `sel_i`.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (req 0 wins).
module alu_arbiter #(
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*DWIDTH-1:0] req_op1_i,
  input  logic [2*DWIDTH-1:0] req_op2_i,
  input  logic [3:0]          req_sel_i,
  output logic [1:0]          rsp_valid_o,
  input  logic [1:0]          rsp_ready_i,
  output logic [DWIDTH-1:0]   rsp_res_o,
  output logic                rsp_zero_o,
  output logic                rsp_neg_o,
  output logic [DWIDTH-1:0]   alu_op1_o,
  output logic [DWIDTH-1:0]   alu_op2_o,
  output logic [1:0]          alu_sel_o,
  input  logic [DWIDTH-1:0]   alu_res_i,
  input  logic                alu_zero_i,
  input  logic                alu_neg_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DWIDTH-1:0] op1_q, op2_q;
  logic [1:0]        sel_q;
  logic              owner_q;
  logic [DWIDTH-1:0] res_q;
  logic              zero_q, neg_q;

  logic              any_req;
  logic              gnt;
  logic              req_hs;
  logic              rsp_hs;
  logic [DWIDTH-1:0] g_op1, g_op2;
  logic [1:0]        g_sel;

  assign any_req = |req_valid_i;
  assign req_hs  = (state_q == IDLE) && any_req;
  assign rsp_hs  = (state_q == RESP) && rsp_ready_i[owner_q];

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Grant select: requester 0 always wins
  always_comb begin
    gnt = ~req_valid_i[0];
  end
`else
  logic last_q;

  // Grant select: on a tie the requester not granted last time wins
  always_comb begin
    if (&req_valid_i) gnt = ~last_q;
    else              gnt = ~req_valid_i[0];
  end

  // Round-robin pointer, moves only on a request handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_q <= 1'b1;
    else if (req_hs) last_q <= gnt;
  end
`endif

  assign g_op1 = gnt ? req_op1_i[2*DWIDTH-1:DWIDTH] : req_op1_i[DWIDTH-1:0];
  assign g_op2 = gnt ? req_op2_i[2*DWIDTH-1:DWIDTH] : req_op2_i[DWIDTH-1:0];
  assign g_sel = gnt ? req_sel_i[3:2] : req_sel_i[1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    busy_o      = (state_q != IDLE);
    unique case (state_q)
      IDLE:    if (any_req) req_ready_o[gnt] = 1'b1;
      RESP:    rsp_valid_o[owner_q] = 1'b1;
      default: ;
    endcase
  end

  // Latch granted operands and owner on a request handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      owner_q <= 1'b0;
    end else if (req_hs) begin
      op1_q   <= g_op1;
      op2_q   <= g_op2;
      sel_q   <= g_sel;
      owner_q <= gnt;
    end
  end

  // Capture ALU result and flags at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q  <= alu_res_i;
      zero_q <= alu_zero_i;
      neg_q  <= alu_neg_i;
    end
  end

  assign alu_op1_o  = op1_q;
  assign alu_op2_o  = op2_q;
  assign alu_sel_o  = sel_q;
  assign rsp_res_o  = res_q;
  assign rsp_zero_o = zero_q;
  assign rsp_neg_o  = neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter
// with a behavioural ALU attached.
module tb_alu_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_op1;
  logic [2*W-1:0] req_op2;
  logic [3:0]    req_sel;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [W-1:0]  rsp_res;
  logic          rsp_zero;
  logic          rsp_neg;
  logic [W-1:0]  alu_op1;
  logic [W-1:0]  alu_op2;
  logic [1:0]    alu_sel;
  logic [W-1:0]  alu_res;
  logic          alu_zero;
  logic          alu_neg;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DWIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op1_i   (req_op1),
    .req_op2_i   (req_op2),
    .req_sel_i   (req_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_res_o   (rsp_res),
    .rsp_zero_o  (rsp_zero),
    .rsp_neg_o   (rsp_neg),
    .alu_op1_o   (alu_op1),
    .alu_op2_o   (alu_op2),
    .alu_sel_o   (alu_sel),
    .alu_res_i   (alu_res),
    .alu_zero_i  (alu_zero),
    .alu_neg_i   (alu_neg),
    .busy_o      (busy)
  );

  // behavioural ALU
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      2'b00: alu_res = alu_op1 + alu_op2;
      2'b01: alu_res = alu_op1 - alu_op2;
      2'b10: alu_res = alu_op1 & alu_op2;
      default: alu_res = alu_op1 | alu_op2;
    endcase
    alu_zero = (alu_res == '0);
    alu_neg  = alu_res[W-1];
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] s);
    req_op1[r*W +: W] = a;
    req_op2[r*W +: W] = b;
    req_sel[r*2 +: 2] = s;
  endtask

  // one full transaction from IDLE with immediate response accept
  task automatic run_single(input int r, input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            input logic [W-1:0] e_res,
                            input logic e_z, input logic e_n);
    logic [1:0] oh;
    oh = (r == 0) ? 2'b01 : 2'b10;
    set_req(r, a, b, 2'b00);
    req_valid = oh;
    rsp_ready = oh;
    #1;
    check("single_ready", req_ready, oh);
    step();
    req_valid = 2'b00;
    check("single_exec_busy", busy, 1);
    check("single_exec_rspv", rsp_valid, 0);
    check("single_alu_op1", alu_op1, a);
    check("single_alu_op2", alu_op2, b);
    step();
    check("single_rspv", rsp_valid, oh);
    check("single_res", rsp_res, e_res);
    check("single_zero", rsp_zero, e_z);
    check("single_neg", rsp_neg, e_n);
    step();
    check("single_idle_busy", busy, 0);
    check("single_idle_rspv", rsp_valid, 0);
    check("single_op1_hold", alu_op1, a);
    rsp_ready = 2'b00;
  endtask

  initial begin
    logic [1:0] exp_g;
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op1   = '0;
    req_op2   = '0;
    req_sel   = '0;
    step();
    step();
    check("rst_rspv", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", req_ready, 0);
    check("rst_op1", alu_op1, 0);
    check("rst_res", rsp_res, 0);
    rst = 1'b0;
    step();

    // single request and flags
    run_single(0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_single(0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    run_single(1, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1'b1);

    // back-pressure
    set_req(0, 32'd3, 32'd4, 2'b00);
    set_req(1, 32'd9, 32'd1, 2'b00);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    step();
    req_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_rspv", rsp_valid, 2'b01);
      check("bp_res", rsp_res, 32'd7);
      check("bp_rdy", req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_hs_rdy", req_ready, 2'b00);
    step();
    check("bp_next_rdy", req_ready, 2'b10);
    rsp_ready = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    check("bp_r1_rspv", rsp_valid, 2'b10);
    check("bp_r1_res", rsp_res, 32'd10);
    step();
    check("bp_idle", busy, 0);

    // wrong-owner ready is ignored
    set_req(0, 32'd2, 32'd2, 2'b00);
    req_valid = 2'b01;
    rsp_ready = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    for (int i = 0; i < 3; i++) begin
      check("wo_rspv", rsp_valid, 2'b01);
      check("wo_busy", busy, 1);
      step();
    end
    rsp_ready = 2'b01;
    step();
    check("wo_done", rsp_valid, 2'b00);
    rsp_ready = 2'b00;

    // asynchronous reset mid-RESP
    set_req(0, 32'd6, 32'd6, 2'b00);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    check("ar_pre_rspv", rsp_valid, 2'b01);
    rst = 1'b1;
    #1;
    check("ar_rspv", rsp_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_op1", alu_op1, 0);
    check("ar_res", rsp_res, 0);
    step();
    rst = 1'b0;

    // arbitration with both requesters always valid
    set_req(0, 32'd10, 32'd1, 2'b00);
    set_req(1, 32'd20, 32'd2, 2'b00);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      #1;
      check("rr_grant", req_ready, exp_g);
      step();
      check("rr_exec_rdy", req_ready, 2'b00);
      step();
      check("rr_rspv", rsp_valid, exp_g);
      check("rr_res", rsp_res, (exp_g == 2'b01) ? 32'd11 : 32'd22);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
